// File: rtl/ro_deframer.sv
// ro_deframer: receive-side deframer for the time-multiplexed readout bus.
// Decodes the active slot from the gray-count step, captures the shared
// eve/pol_eve lines on the falling edge, and queues {slot, eve, pol} records
// in a small FIFO with a valid/ready output.
// Optional feature macro: RO_EVENT_FILTER_EN (skip records with eve=pol=0).
`timescale 1ns/1ps

module ro_deframer #(
   parameter int N_SLOT     = 19,
   parameter int IDX_W      = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 8
) (
   input  logic              clk_master,
   input  logic              rstb,
   input  logic [N_SLOT-1:0] gray,
   input  logic              out_mux_eve,
   input  logic              out_mux_pol_eve,
   input  logic              ev_ready,
   output logic              ev_valid,
   output logic [IDX_W-1:0]  ev_slot,
   output logic              ev_eve,
   output logic              ev_pol,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              gray_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [IDX_W-1:0] slot;
      logic             eve;
      logic             pol;
   } rec_t;

   logic [N_SLOT-1:0] gray_prev;
   logic [N_SLOT-1:0] diff;
   logic [N_SLOT-1:0] cap_diff;
   logic              cap_eve;
   logic              cap_pol;

   logic              one_hot;
   logic              multi_hot;
   logic              push;
   logic [IDX_W-1:0]  hot_idx;

   rec_t              mem [FIFO_DEPTH];
   rec_t              head;
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic              empty;
   logic              full;
   logic              pop;
   logic              wr_en;
   logic              drop;

   // Stage A: remember the gray value held just before this edge's update.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) gray_prev <= '0;
      else       gray_prev <= gray;
   end

   // During the high phase the toggled bit identifies the slot driving the bus.
   assign diff = gray ^ gray_prev;

   // Stage B: sample the bus and the slot step while the driver is still enabled.
   always_ff @(negedge clk_master or negedge rstb) begin
      if (!rstb) begin
         cap_diff <= '0;
         cap_eve  <= 1'b0;
         cap_pol  <= 1'b0;
      end else begin
         cap_diff <= diff;
         cap_eve  <= out_mux_eve;
         cap_pol  <= out_mux_pol_eve;
      end
   end

   // Stage C decode: priority-encode the captured step into a slot index.
   // NOTE: a default ahead of the loop keeps this purely combinational (no latch).
   always_comb begin
      hot_idx = '0;
      for (int i = 0; i < N_SLOT; i++) begin
         if (cap_diff[i]) hot_idx = IDX_W'(i);
      end
   end

   assign one_hot   = (cap_diff != '0) && ((cap_diff & (cap_diff - N_SLOT'(1))) == '0);
   assign multi_hot = (cap_diff != '0) && !one_hot;

`ifdef RO_EVENT_FILTER_EN
   assign push = one_hot & (cap_eve | cap_pol);
`else
   assign push = one_hot;
`endif

   // FIFO bookkeeping: one extra pointer bit separates full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop   = ev_valid & ev_ready;
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   // Record storage write port.
   // NOTE: storage is not reset; ev_* are gated by ev_valid so stale entries never show.
   always_ff @(posedge clk_master) begin
      if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= '{slot: hot_idx, eve: cap_eve, pol: cap_pol};
   end

   // Pointers, saturating drop counter and sticky gray-step error flag.
   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         drop_cnt <= '0;
         gray_err <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
         if (multi_hot) gray_err <= 1'b1;
      end
   end

   assign head     = mem[rd_ptr[PTR_W-1:0]];
   assign ev_valid = ~empty;
   assign ev_slot  = ev_valid ? head.slot : '0;
   assign ev_eve   = ev_valid ? head.eve  : 1'b0;
   assign ev_pol   = ev_valid ? head.pol  : 1'b0;

endmodule

// File: tb/tb_ro_deframer.sv
// tb_ro_deframer: randomized bench for ro_deframer with a queue scoreboard.
// The bench plays gray_count plus the readout blocks; a transaction-level
// model predicts FIFO occupancy, drops and gray errors.
`timescale 1ns/1ps

module tb_ro_deframer;

   localparam int N_SLOT   = 19;
   localparam int IDX_W    = 5;
   localparam int DEPTH    = 4;
   localparam int DROP_W   = 8;
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   typedef struct packed {
      logic [IDX_W-1:0] slot;
      logic             eve;
      logic             pol;
   } rec_t;

   logic              clk_master;
   logic              rstb;
   logic [N_SLOT-1:0] gray;
   logic              out_mux_eve;
   logic              out_mux_pol_eve;
   logic              ev_ready;
   logic              ev_valid;
   logic [IDX_W-1:0]  ev_slot;
   logic              ev_eve;
   logic              ev_pol;
   logic [DROP_W-1:0] drop_cnt;
   logic              gray_err;

   ro_deframer #(
      .N_SLOT(N_SLOT), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .DROP_W(DROP_W)
   ) dut (
      .clk_master(clk_master), .rstb(rstb), .gray(gray),
      .out_mux_eve(out_mux_eve), .out_mux_pol_eve(out_mux_pol_eve),
      .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_slot(ev_slot),
      .ev_eve(ev_eve), .ev_pol(ev_pol), .drop_cnt(drop_cnt), .gray_err(gray_err)
   );

   initial clk_master = 1'b0;
   always #5 clk_master = ~clk_master;

   int checks = 0;
   int errors = 0;

   // Scoreboard and transaction-level model state.
   rec_t              exp_q[$];
   int                model_cnt  = 0;
   int                model_drop = 0;
   bit                model_err  = 1'b0;
   bit                pend_v     = 1'b0;
   bit                pend_err   = 1'b0;
   rec_t              pend_r;
   logic [N_SLOT-1:0] cnt;
   bit                slot_eve [N_SLOT];
   bit                slot_pol [N_SLOT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int lowest_set(input logic [N_SLOT-1:0] d);
      for (int i = 0; i < N_SLOT; i++) if (d[i]) return i;
      return 0;
   endfunction

   // One master cycle. Applies the model for the posedge just passed, then
   // moves gray_count and lets the toggled slot drive the bus for the high phase.
   task automatic cycle_g(input bit adv, input bit frc, input logic [N_SLOT-1:0] gval,
                          input bit rdy);
      logic [N_SLOT-1:0] g_old;
      logic [N_SLOT-1:0] d;
      int                k;
      int                ones;
      @(posedge clk_master);
      #1;
      if (rstb) begin
         if (model_cnt > 0 && ev_ready) model_cnt--;
         if (pend_err) model_err = 1'b1;
         if (pend_v) begin
            if (model_cnt < DEPTH) begin
               model_cnt++;
               exp_q.push_back(pend_r);
            end else if (model_drop < DROP_MAX) begin
               model_drop++;
            end
         end
      end
      pend_v   = 1'b0;
      pend_err = 1'b0;
      g_old = gray;
      if (frc) gray = gval;
      else if (adv) begin
         cnt  = cnt + 1'b1;
         gray = cnt ^ (cnt >> 1);
      end
      d    = gray ^ g_old;
      ones = $countones(d);
      k    = lowest_set(d);
      out_mux_eve     = 1'b0;
      out_mux_pol_eve = 1'b0;
      if (ones == 1) begin
         out_mux_eve     = slot_eve[k];
         out_mux_pol_eve = slot_pol[k];
      end
      ev_ready = rdy;
      if (rstb) begin
         if (ones == 1) begin
            pend_v = 1'b1;
`ifdef RO_EVENT_FILTER_EN
            pend_v = slot_eve[k] | slot_pol[k];
`endif
            pend_r = '{slot: IDX_W'(k), eve: slot_eve[k], pol: slot_pol[k]};
         end else if (ones > 1) begin
            pend_err = 1'b1;
         end
      end
      @(negedge clk_master);
      #1;
   endtask

   task automatic cycle(input bit adv, input bit rdy);
      cycle_g(adv, 1'b0, '0, rdy);
   endtask

   // Asynchronous reset in the low phase; release in a later low phase.
   task automatic do_reset(input bit zero_gray, input int hold);
      #2;
      rstb = 1'b0;
      model_cnt  = 0;
      model_drop = 0;
      model_err  = 1'b0;
      pend_v     = 1'b0;
      pend_err   = 1'b0;
      exp_q.delete();
      #1;
      check("rst_valid", ev_valid, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_gray_err", gray_err, 0);
      check("rst_slot", ev_slot, 0);
      if (zero_gray) begin
         cnt  = '0;
         gray = '0;
      end
      repeat (hold) cycle(!zero_gray, 1'b1);
      rstb = 1'b1;
   endtask

   // Monitor: compare head against the scoreboard whenever a record is shown.
   always @(negedge clk_master) begin
      if (rstb) begin
         check("valid", ev_valid, (model_cnt != 0));
         check("drop_cnt", drop_cnt, model_drop);
         check("gray_err", gray_err, model_err);
         if (ev_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_record", exp_q.size(), 1);
            end else begin
               check("rec_slot", ev_slot, exp_q[0].slot);
               check("rec_eve", ev_eve, exp_q[0].eve);
               check("rec_pol", ev_pol, exp_q[0].pol);
               if (ev_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int n;
      rstb = 1'b1; gray = '0; cnt = '0;
      out_mux_eve = 1'b0; out_mux_pol_eve = 1'b0; ev_ready = 1'b1;
      for (int s = 0; s < N_SLOT; s++) begin
         slot_eve[s] = 1'($urandom_range(0, 1));
         slot_pol[s] = 1'($urandom_range(0, 1));
      end
      slot_eve[0] = 1'b1;
      slot_pol[0] = 1'b0;
      #1 rstb = 1'b0;
      #1;
      check("init_valid", ev_valid, 0);
      check("init_slot", ev_slot, 0);
      check("init_eve", ev_eve, 0);
      check("init_pol", ev_pol, 0);
      check("init_drop", drop_cnt, 0);
      check("init_gray_err", gray_err, 0);

      // Counter running through reset; release so the next toggle is bit 0.
      repeat (3) cycle(1'b1, 1'b1);
      if (cnt[0]) cycle(1'b1, 1'b1);
      rstb = 1'b1;
      found = 1'b0;
      n = 0;
      while (!found && n < 6) begin
         cycle(1'b1, 1'b1);
         n++;
         found = ev_valid;
      end
      check("first_rec_seen", found, 1);
      check("first_rec_cycles", n, 2);
      check("first_rec_slot", ev_slot, 0);
      check("first_rec_eve", ev_eve, 1);
      check("first_rec_pol", ev_pol, 0);

      // Random bus data, random stalls and random backpressure.
      for (int blk = 0; blk < 8; blk++) begin
         for (int s = 0; s < N_SLOT; s++) begin
            slot_eve[s] = 1'($urandom_range(0, 1));
            slot_pol[s] = 1'($urandom_range(0, 1));
         end
         repeat (40) cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
      end

      // Slot 2 carries eve=0, pol=1 with the consumer always ready.
      slot_eve[2] = 1'b0;
      slot_pol[2] = 1'b1;
      repeat (16) cycle(1'b1, 1'b1);

      // Backpressure: 10 pushes into a 4-deep FIFO, then drain in order.
      do_reset(1'b0, 2);
      repeat (10) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      check("bp_drop", drop_cnt, 6);
      check("bp_valid", ev_valid, 1);
      repeat (6) cycle(1'b0, 1'b1);
      check("bp_drained_valid", ev_valid, 0);
      check("bp_drained_sb", exp_q.size(), 0);

      // Drop counter saturation.
      do_reset(1'b0, 2);
      repeat (270) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      check("drop_saturated", drop_cnt, DROP_MAX);
      repeat (6) cycle(1'b0, 1'b1);

      // Two-bit gray step: no record, sticky error until reset.
      do_reset(1'b1, 2);
      repeat (2) cycle(1'b0, 1'b1);
      check("gerr_before", gray_err, 0);
      cycle_g(1'b0, 1'b1, N_SLOT'(3), 1'b1);
      cnt = N_SLOT'(2);
      cycle(1'b0, 1'b1);
      check("gerr_set", gray_err, 1);
      check("gerr_no_push", ev_valid, 0);
      repeat (3) cycle(1'b1, 1'b1);
      check("gerr_sticky", gray_err, 1);

      // Reset with three records queued; nothing stale may follow.
      do_reset(1'b0, 2);
      n = 0;
      while (model_cnt < 3 && n < 10) begin
         cycle(1'b1, 1'b0);
         n++;
      end
      check("mid_queued", ev_valid, 1);
      do_reset(1'b0, 2);
      repeat (20) cycle(1'b1, 1'b1);

      // Only slot 1 carries a non-zero record.
      for (int s = 0; s < N_SLOT; s++) begin
         slot_eve[s] = 1'b0;
         slot_pol[s] = 1'b0;
      end
      slot_eve[1] = 1'b1;
      do_reset(1'b0, 2);
      repeat (60) cycle(1'b1, 1'b1);
`ifdef RO_EVENT_FILTER_EN
      check("filter_drop", drop_cnt, 0);
`endif

      repeat (8) cycle(1'b0, 1'b1);
      check("final_sb_empty", exp_q.size(), 0);
      check("final_valid", ev_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ro_deframer.md
Name: ro_deframer

Overview:
- Receive-side counterpart of the per-core readout blocks.
- Readout blocks time-multiplex their eve/pol_eve bits onto two shared tri-state lines (out_mux_eve, out_mux_pol_eve). Each block drives during the clk_master high phase that follows a toggle of its gray-counter bit.
- ro_deframer decodes the active slot from the gray count, captures both lines, and pushes {slot, eve, pol_eve} records into a small FIFO with a valid/ready output.

Parameters:
N_SLOT, 19, number of gray bits / readout slots
IDX_W, 5, slot index width, ceil(log2(N_SLOT))
FIFO_DEPTH, 4, record FIFO depth (power of 2, >=2)
DROP_W, 8, saturating drop-counter width

Ports:
clk_master  input  1  master clock, same clock as gray_count
rstb  input  1  asynchronous reset, active-low
gray  input  N_SLOT  gray_count output, updates on posedge clk_master
out_mux_eve  input  1  shared eve readout line
out_mux_pol_eve  input  1  shared pol_eve readout line
ev_ready  input  1  downstream consumer ready
ev_valid  output  1  FIFO head valid
ev_slot  output  IDX_W  slot index of head record
ev_eve  output  1  eve bit of head record
ev_pol  output  1  pol_eve bit of head record
drop_cnt  output  DROP_W  records dropped on full FIFO, saturating
gray_err  output  1  sticky: non-one-hot gray step seen

Behaviour:
- Single clock clk_master; rstb asynchronous, active-low. All state clears on rstb=0.
- Reset values: ev_valid=0, ev_slot=0, ev_eve=0, ev_pol=0, drop_cnt=0, gray_err=0, FIFO empty, gray_prev=0.
- Stage A (posedge): gray_prev <= gray. This captures the value held before gray_count updates on the same edge. During the following high phase, diff = gray ^ gray_prev.
- Stage B (negedge clk_master), the only negedge logic in the block:
  - cap_eve <= out_mux_eve and cap_pol <= out_mux_pol_eve.
  - cap_diff <= diff.
  - The bus is sampled before the driving block's edge_ff is reset by clk_master low. Timing relies on edge_ff reset plus tbuf disable delay exceeding the capture hold time.
- Stage C (next posedge): decode cap_diff.
  - Exactly one bit k set: push {k, cap_eve, cap_pol}.
  - cap_diff == 0: no push. This covers the first cycle after reset and a stalled counter.
  - Two or more bits set: no push; gray_err <= 1 (sticky until rstb).
- Capture-to-push latency is 1 posedge after the sampling negedge. The record is visible on ev_* at the first posedge after the push (FIFO write then read, no bypass).
- FIFO:
  - Head shown on ev_* while ev_valid=1. Pop on posedge when ev_valid & ev_ready.
  - ev_* stay stable while ev_valid & ~ev_ready.
  - Push and pop in the same cycle are both performed, including when full (pop frees the slot) and when empty (push lands, ev_valid=1 next cycle).
  - Push while full with no pop: record discarded; drop_cnt += 1, saturating at 2^DROP_W-1.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by one extra pointer bit.
- Reset mid-operation discards all records, including captured Stage B data. The first valid push needs two posedges plus one negedge after rstb rises.
- Undriven (z/x) bus values at capture are stored as-is; no checking.

Optional Feature:
- Macro RO_EVENT_FILTER_EN.
- Defined: Stage C pushes only if cap_eve | cap_pol is 1. Zero records are skipped and do not count as drops.
- Undefined: every valid one-hot slot pushes a record regardless of bit values.

Test Plan:
- Reset release with gray_count running and a readout block driving slot 0 with eve=1, pol=0 → first record ev_slot=0, ev_eve=1, ev_pol=0. Slot sequence thereafter follows the gray bit-toggle order 0,1,0,2,0,1,0,3…
- Drive slot 2 with eve=0, pol=1; ev_ready=1 → record {2,0,1} appears exactly 1 posedge after the Stage C push and pops the same cycle.
- Hold ev_ready=0 for 10 master cycles → ev_valid=1 after the first push, head stable, FIFO holds 4 records, drop_cnt=6. ev_ready=1 then drains the 4 records in original order.
- Force gray from 0x00000 to 0x00003 in one step → no push; gray_err=1 and held until rstb=0.
- Assert rstb=0 mid-stream with 3 records queued → ev_valid=0, drop_cnt=0 immediately (asynchronous). No stale record emerges after release.
- With RO_EVENT_FILTER_EN, drive eve=pol=0 on all slots except slot 1 (eve=1) → only {1,1,0} records are emitted; drop_cnt stays 0.
